// File: rtl/tl_async_wr_stage.sv
// -----------------------------------------------------------------------------
// tl_async_wr_stage
//
// Write-side staging buffer in front of an asynchronous FIFO. Upstream requests
// land in a two-entry skid buffer (EMPTY / ONE / TWO). The head entry drives the
// FIFO write port straight from flops. An outstanding-request limiter keeps the
// number of issued, unretired requests at or below MaxOut. Retirements arrive
// as single-cycle pulses that are already in the clk_wr_i domain.
//
// Optional build macro:
//   TL_ASYNC_WR_STALL_CNT_EN - when defined, stall_cnt_o counts the cycles in
//                              which buffered data is held back only by the
//                              outstanding limit. The count saturates at 16'hFFFF.
//                              When undefined, stall_cnt_o is tied to 0 and no
//                              counter flops exist.
//
// Ports:
//   clk_wr_i        in   1       write-domain clock
//   rst_wr_ni       in   1       asynchronous active-low reset
//   req_valid_i     in   1       upstream request valid
//   req_ready_o     out  1       upstream request ready (registered)
//   req_data_i      in   Width   upstream packed request
//   fifo_wvalid_o   out  1       async FIFO write valid (registered)
//   fifo_wready_i   in   1       async FIFO write ready
//   fifo_wdata_o    out  Width   async FIFO write data (registered)
//   fifo_wdepth_i   in   DepthW  async FIFO fill level (debug only, unused here)
//   rsp_done_i      in   1       one response retired (pulse)
//   outstanding_o   out  OutW    issued but unretired requests
//   idle_o          out  1       buffer empty and nothing outstanding
//   err_underflow_o out  1       sticky: retirement seen with nothing outstanding
//   stall_cnt_o     out  16      limiter-stall cycle count
// -----------------------------------------------------------------------------
module tl_async_wr_stage #(
  parameter int Width  = 16,
  parameter int Depth  = 3,
  parameter int MaxOut = 4,
  parameter int DepthW = $clog2(Depth + 1),
  parameter int OutW   = $clog2(MaxOut + 1)
) (
  input  logic              clk_wr_i,
  input  logic              rst_wr_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [Width-1:0]  req_data_i,
  output logic              fifo_wvalid_o,
  input  logic              fifo_wready_i,
  output logic [Width-1:0]  fifo_wdata_o,
  input  logic [DepthW-1:0] fifo_wdepth_i,
  input  logic              rsp_done_i,
  output logic [OutW-1:0]   outstanding_o,
  output logic              idle_o,
  output logic              err_underflow_o,
  output logic [15:0]       stall_cnt_o
);

  localparam logic [OutW-1:0] MAX_OUT_C = OutW'(MaxOut);
  localparam logic [OutW-1:0] OUT_INC_C = OutW'(1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e           state_p0, state_nxt;
  logic [Width-1:0] head_p0, head_nxt;
  logic [Width-1:0] skid_p0, skid_nxt;
  logic [OutW-1:0]  out_p0, out_nxt;
  logic             rdy_p0, rdy_nxt;
  logic             vld_p0, vld_nxt;
  logic             err_p0, err_nxt;
  logic             accept, issue;

  // The FIFO fill level is carried for debug visibility only.
  logic unused_wdepth;
  assign unused_wdepth = ^fifo_wdepth_i;

  assign accept = req_valid_i && rdy_p0;
  assign issue  = vld_p0 && fifo_wready_i;

  // Skid-buffer next state. The head only reloads when it is consumed
  // (or empty), so the FIFO sees stable data while it is stalled.
  always_comb begin
    state_nxt = state_p0;
    head_nxt  = head_p0;
    skid_nxt  = skid_p0;
    unique case (state_p0)
      EMPTY: begin
        if (accept) begin
          state_nxt = ONE;
          head_nxt  = req_data_i;
        end
      end
      ONE: begin
        unique case ({accept, issue})
          2'b10: begin
            state_nxt = TWO;
            skid_nxt  = req_data_i;
          end
          2'b01: state_nxt = EMPTY;
          2'b11: head_nxt  = req_data_i;
          default: ;
        endcase
      end
      TWO: begin
        if (issue) begin
          state_nxt = ONE;
          head_nxt  = skid_p0;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Outstanding counter. A retirement with nothing outstanding (and nothing
  // issuing) leaves the count at zero and latches the underflow flag.
  always_comb begin
    out_nxt = out_p0;
    err_nxt = err_p0;
    if (issue && !rsp_done_i) begin
      out_nxt = out_p0 + OUT_INC_C;
    end else if (rsp_done_i && !issue) begin
      if (out_p0 == '0) begin
        err_nxt = 1'b1;
      end else begin
        out_nxt = out_p0 - OUT_INC_C;
      end
    end
  end

  // Valid and ready are precomputed from next-cycle state so both leave the
  // block straight from flops; ready has no path from fifo_wready_i.
  assign vld_nxt = (state_nxt != EMPTY) && (out_nxt < MAX_OUT_C);
  assign rdy_nxt = (state_nxt != TWO);

  // ---- stage p0: registered control and head data ----
  always_ff @(posedge clk_wr_i or negedge rst_wr_ni) begin
    if (!rst_wr_ni) begin
      state_p0 <= EMPTY;
      rdy_p0   <= 1'b1;
      vld_p0   <= 1'b0;
      out_p0   <= '0;
      err_p0   <= 1'b0;
      head_p0  <= '0;
    end else begin
      state_p0 <= state_nxt;
      rdy_p0   <= rdy_nxt;
      vld_p0   <= vld_nxt;
      out_p0   <= out_nxt;
      err_p0   <= err_nxt;
      head_p0  <= head_nxt;
    end
  end

  always_ff @(posedge clk_wr_i) begin
    skid_p0 <= skid_nxt;
  end

  assign req_ready_o     = rdy_p0;
  assign fifo_wvalid_o   = vld_p0;
  assign fifo_wdata_o    = head_p0;
  assign outstanding_o   = out_p0;
  assign err_underflow_o = err_p0;
  assign idle_o          = (state_p0 == EMPTY) && (out_p0 == '0);

`ifdef TL_ASYNC_WR_STALL_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

  logic [15:0] stall_p0;

  // ---- stage p0: limiter-stall counter ----
  always_ff @(posedge clk_wr_i or negedge rst_wr_ni) begin
    if (!rst_wr_ni) begin
      stall_p0 <= '0;
    end else if ((state_p0 != EMPTY) && (out_p0 == MAX_OUT_C)) begin
      stall_p0 <= sat_inc16(stall_p0);
    end
  end

  assign stall_cnt_o = stall_p0;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_tl_async_wr_stage.sv
// -----------------------------------------------------------------------------
// tb_tl_async_wr_stage
//
// Directed scenarios followed by a randomized run. A reference model tracks the
// buffered requests as a queue, the outstanding count as an integer, and the
// underflow / stall status, and predicts every visible output each cycle.
// -----------------------------------------------------------------------------
module tb_tl_async_wr_stage;

  localparam int Width  = 16;
  localparam int Depth  = 3;
  localparam int MaxOut = 4;
  localparam int DepthW = $clog2(Depth + 1);
  localparam int OutW   = $clog2(MaxOut + 1);

  logic              clk_wr_i;
  logic              rst_wr_ni;
  logic              req_valid_i;
  logic              req_ready_o;
  logic [Width-1:0]  req_data_i;
  logic              fifo_wvalid_o;
  logic              fifo_wready_i;
  logic [Width-1:0]  fifo_wdata_o;
  logic [DepthW-1:0] fifo_wdepth_i;
  logic              rsp_done_i;
  logic [OutW-1:0]   outstanding_o;
  logic              idle_o;
  logic              err_underflow_o;
  logic [15:0]       stall_cnt_o;

  tl_async_wr_stage #(
    .Width (Width),
    .Depth (Depth),
    .MaxOut(MaxOut)
  ) dut (
    .clk_wr_i       (clk_wr_i),
    .rst_wr_ni      (rst_wr_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_data_i     (req_data_i),
    .fifo_wvalid_o  (fifo_wvalid_o),
    .fifo_wready_i  (fifo_wready_i),
    .fifo_wdata_o   (fifo_wdata_o),
    .fifo_wdepth_i  (fifo_wdepth_i),
    .rsp_done_i     (rsp_done_i),
    .outstanding_o  (outstanding_o),
    .idle_o         (idle_o),
    .err_underflow_o(err_underflow_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  initial clk_wr_i = 1'b0;
  always #5 clk_wr_i = ~clk_wr_i;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [Width-1:0] q[$];
  logic [Width-1:0] issued[$];
  int               m_out;
  bit               m_err;
  int               m_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_stall();
`ifdef TL_ASYNC_WR_STALL_CNT_EN
    return m_stall;
`else
    return 0;
`endif
  endfunction

  task automatic model_clear();
    q.delete();
    issued.delete();
    m_out   = 0;
    m_err   = 0;
    m_stall = 0;
  endtask

  // One clock cycle: drive inputs just after a negedge, check the registered
  // outputs against the model, then advance the model across the posedge.
  task automatic cycle(input bit v, input logic [Width-1:0] d, input bit wr,
                       input bit rsp, output bit acc);
    bit exp_vld;
    bit iss;
    req_valid_i   = v;
    req_data_i    = d;
    fifo_wready_i = wr;
    rsp_done_i    = rsp;
    #1;
    exp_vld = (q.size() > 0) && (m_out < MaxOut);
    chk("ready", req_ready_o, q.size() < 2);
    chk("wvalid", fifo_wvalid_o, exp_vld);
    if (exp_vld) chk("wdata", fifo_wdata_o, q[0]);
    chk("outstanding", outstanding_o, m_out);
    chk("idle", idle_o, (q.size() == 0) && (m_out == 0));
    chk("underflow", err_underflow_o, m_err);
    chk("stall_cnt", stall_cnt_o, exp_stall());
    acc = v && (q.size() < 2);
    iss = exp_vld && wr;
    @(posedge clk_wr_i);
    if ((q.size() > 0) && (m_out == MaxOut) && (m_stall < 65535)) m_stall++;
    if (iss) issued.push_back(q.pop_front());
    if (acc) q.push_back(d);
    if (iss && !rsp) m_out++;
    else if (rsp && !iss) begin
      if (m_out > 0) m_out--;
      else m_err = 1;
    end
    @(negedge clk_wr_i);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, req_ready_o, 1);
    chk({tag, "_wvalid"}, fifo_wvalid_o, 0);
    chk({tag, "_wdata"}, fifo_wdata_o, 0);
    chk({tag, "_outstanding"}, outstanding_o, 0);
    chk({tag, "_idle"}, idle_o, 1);
    chk({tag, "_underflow"}, err_underflow_o, 0);
    chk({tag, "_stall"}, stall_cnt_o, 0);
  endtask

  // Synchronous-style reset pulse issued from a negedge.
  task automatic do_reset();
    req_valid_i   = 1'b0;
    fifo_wready_i = 1'b0;
    rsp_done_i    = 1'b0;
    rst_wr_ni     = 1'b0;
    #1;
    check_reset_vals("rst");
    @(negedge clk_wr_i);
    rst_wr_ni = 1'b1;
    model_clear();
  endtask

  // Offer n requests base, base+1, ... holding each until accepted.
  task automatic run_seq(input logic [Width-1:0] base, input int n, input bit wr,
                         input bit rsp, input int ncycles);
    int idx;
    bit acc;
    idx = 0;
    for (int c = 0; c < ncycles; c++) begin
      cycle(idx < n, base + Width'(idx), wr, rsp, acc);
      if (acc) idx++;
    end
  endtask

  initial begin
    bit acc;
    req_valid_i   = 1'b0;
    req_data_i    = '0;
    fifo_wready_i = 1'b0;
    fifo_wdepth_i = '0;
    rsp_done_i    = 1'b0;
    model_clear();
    rst_wr_ni = 1'b1;
    #1;
    rst_wr_ni = 1'b0;
    #1;
    check_reset_vals("init");
    @(negedge clk_wr_i);
    rst_wr_ni = 1'b1;

    // Back-to-back stream 0x0001..0x0008, retirement pulsed every cycle.
    run_seq(16'h0001, 8, 1'b1, 1'b1, 9);
    chk("b2b_count", issued.size(), 8);
    for (int i = 0; i < 8 && i < issued.size(); i++)
      chk("b2b_order", issued[i], 16'h0001 + 16'(i));
    run_seq(16'h0000, 0, 1'b1, 1'b0, 2);

    // FIFO stalled with three offered requests: two accepted, head held.
    do_reset();
    run_seq(16'h00A1, 3, 1'b0, 1'b0, 4);
    chk("stall_ready", req_ready_o, 0);
    chk("stall_wdata", fifo_wdata_o, 16'h00A1);
    chk("stall_wvalid", fifo_wvalid_o, 1);
    // Third request (0x00A3) is still pending: keep offering it while draining.
    begin
      int idx;
      idx = 2;
      for (int c = 0; c < 8; c++) begin
        cycle(idx < 3, 16'h00A1 + 16'(idx), 1'b1, 1'b0, acc);
        if (acc) idx++;
      end
    end
    chk("stall_drain_cnt", issued.size(), 3);

    // Outstanding limit: 6 requests, no retirements.
    do_reset();
    run_seq(16'h0101, 6, 1'b1, 1'b0, 15);
    chk("lim_outstanding", outstanding_o, 4);
    chk("lim_wvalid", fifo_wvalid_o, 0);
    chk("lim_issued", issued.size(), 4);
`ifdef TL_ASYNC_WR_STALL_CNT_EN
    chk("lim_stall10", stall_cnt_o, 10);
`else
    chk("lim_stall10", stall_cnt_o, 0);
`endif
    cycle(1'b0, '0, 1'b1, 1'b1, acc);
    cycle(1'b0, '0, 1'b1, 1'b0, acc);
    chk("lim_fifth_cnt", issued.size(), 5);
    if (issued.size() == 5) chk("lim_fifth_data", issued[4], 16'h0105);

    // Issue and retirement in the same cycle at outstanding == 2.
    do_reset();
    run_seq(16'h0201, 3, 1'b1, 1'b0, 3);
    chk("same_pre", outstanding_o, 2);
    chk("same_pre_vld", fifo_wvalid_o, 1);
    cycle(1'b0, '0, 1'b1, 1'b1, acc);
    chk("same_post", outstanding_o, 2);

    // Retirement with nothing outstanding.
    do_reset();
    cycle(1'b0, '0, 1'b0, 1'b1, acc);
    chk("uf_flag", err_underflow_o, 1);
    chk("uf_outstanding", outstanding_o, 0);
    run_seq(16'h0000, 0, 1'b0, 1'b0, 3);
    chk("uf_sticky", err_underflow_o, 1);

    // Asynchronous reset while holding two entries.
    do_reset();
    run_seq(16'h0301, 3, 1'b0, 1'b0, 3);
    chk("ar_two_ready", req_ready_o, 0);
    chk("ar_two_idle", idle_o, 0);
    #2;
    rst_wr_ni = 1'b0;
    #1;
    check_reset_vals("async_rst");
    model_clear();
    @(negedge clk_wr_i);
    rst_wr_ni = 1'b1;
    run_seq(16'h0401, 2, 1'b1, 1'b1, 4);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      cycle(($urandom % 4) != 0, Width'($urandom), ($urandom % 3) != 0,
            ($urandom % 3) == 0, acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
